// File: rtl/char_uart_tx_pkg.sv
// Shared types and constants for the character UART transmitter.
package char_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/char_uart_tx_if.sv
// Byte-stream source interface: one byte per clock while act is high, no backpressure.
interface char_uart_tx_if;
    import char_uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 act;

    modport master (output data, output act);
    modport slave  (input  data, input  act);

endinterface

// File: rtl/char_uart_tx_byte_fifo.sv
// Single-clock byte FIFO with first-word-fall-through head; pushes while full are ignored.
module byte_fifo
    import char_uart_pkg::*;
#(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic [FIFO_AW:0]     count,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 push_ok, pop_ok;

    assign full    = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // Full is judged on the pre-edge count, so a pop cannot make room for a same-cycle push.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/char_uart_tx.sv
// Queues source bytes in a FIFO and shifts them out as 8N1 UART frames; counts dropped bytes.
module char_uart_tx
    import char_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    char_uart_tx_if.slave         src,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_full,
    output logic                  o_overflow,
    output logic [DROP_CNT_W-1:0] o_drop_count
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_t             state_q;
    logic [TW-1:0]         timer_q;
    logic [2:0]            bit_idx_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  tx_q;
    logic                  ovf_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [DATA_BITS-1:0]  fifo_dout;
    logic [FIFO_AW:0]      fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  pop, drop, timer_last;

    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign drop       = src.act && fifo_full;
    assign timer_last = (timer_q == TIMER_LAST);

    byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (i_clock),
        .rst   (i_reset),
        .push  (src.act),
        .pop   (pop),
        .din   (src.data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q <= fifo_dout;
                        timer_q <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (timer_last) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                DATA: begin
                    if (timer_last) begin
                        timer_q <= '0;
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            // tx is registered, so it takes the bit that becomes shift[0] after this edge.
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (timer_last) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (drop) ovf_q <= 1'b1;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_tx         = tx_q;
    assign o_busy       = (state_q != IDLE) || (fifo_count != '0);
    assign o_full       = fifo_full;
    assign o_overflow   = ovf_q;
    assign o_drop_count = drop_cnt_q;

endmodule
